stopwatch_ctrl: RTL and testbench

- Run/pause/clear controller for a chain of NUM_DIGITS cascaded BCD (0-9) digit counters, advanced by an internal tick prescaler.
- A scan scheduler time-multiplexes the digits onto one shared segment7 decoder.
- Sits between debounced, pulsed button inputs and the board's multiplexed 7-segment display.

---
 rtl/stopwatch_pkg.sv | 17 +
 rtl/segment7.sv | 32 +++
 rtl/stopwatch_ctrl.sv | 133 +++++++++++++
 tb/tb_stopwatch_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller and its display decoder.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX   = 4'd9;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [3:0] bcd_inc(input logic [3:0] d);
    return (d == BCD_MAX) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/segment7.sv
// Hex to 7-segment decoder, active-low segments, bit order g..a.
module segment7
  import stopwatch_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/clear stopwatch over cascaded BCD digits with a scanned 7-segment display.
// Build option STOPWATCH_HOLD_ON_OVF_EN: freeze at all-9s and pause instead of wrapping.
//
// state    | meaning
// ST_IDLE  | cleared, prescaler held at 0
// ST_RUN   | prescaler counting, digits advance on tick
// ST_PAUSE | prescaler and digits frozen mid-period
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 50000,
  parameter int SCAN_DIV   = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_stop,
  input  logic                  clear,
  output logic                  running,
  output logic                  overflow,
  output logic [NUM_DIGITS-1:0] digit_sel,
  output logic [3:0]            digit_bcd,
  output logic [6:0]            hout
);

  localparam int TICK_W = $clog2(TICK_DIV);
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W  = $clog2(NUM_DIGITS);

`ifdef STOPWATCH_HOLD_ON_OVF_EN
  localparam bit HOLD_ON_OVF = 1'b1;
`else
  localparam bit HOLD_ON_OVF = 1'b0;
`endif

  state_t            state, next_state;
  logic [TICK_W-1:0] presc;
  logic              tick, all_nines, ovf_event;
  logic              in_run, in_idle, ss_ok;
  logic [3:0]        digit [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] is_nine, carry;
  logic [SCAN_W-1:0] scan_cnt;
  logic [IDX_W-1:0]  scan_idx, next_idx;
  logic              scan_wrap;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (clear) begin
      next_state = ST_IDLE;
    end else if (HOLD_ON_OVF && ovf_event) begin
      next_state = ST_PAUSE;
    end else if (start_stop && ss_ok) begin
      case (state)
        ST_IDLE:  next_state = ST_RUN;
        ST_RUN:   next_state = ST_PAUSE;
        ST_PAUSE: next_state = ST_RUN;
        default:  next_state = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    in_run  = (state == ST_RUN);
    in_idle = (state == ST_IDLE);
    // In hold mode a latched overflow locks out start_stop until clear.
    ss_ok   = !(HOLD_ON_OVF && overflow);
  end

  assign tick      = in_run && (presc == TICK_W'(TICK_DIV - 1));
  assign all_nines = &is_nine;
  assign ovf_event = tick && all_nines;

  always_ff @(posedge clk) begin
    if (rst) running <= 1'b0;
    else     running <= (next_state == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst || clear || in_idle) presc <= '0;
    else if (tick)               presc <= '0;
    else if (in_run)             presc <= presc + TICK_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst || clear)   overflow <= 1'b0;
    else if (ovf_event) overflow <= 1'b1;
  end

  assign carry[0] = tick && !(HOLD_ON_OVF && all_nines);

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign is_nine[gi] = (digit[gi] == BCD_MAX);
    if (gi > 0) begin : g_carry
      assign carry[gi] = carry[gi-1] && is_nine[gi-1];
    end
    always_ff @(posedge clk) begin
      if (rst || clear)   digit[gi] <= 4'd0;
      else if (carry[gi]) digit[gi] <= bcd_inc(digit[gi]);
    end
  end

  always_comb begin
    scan_wrap = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
    next_idx  = scan_idx;
    if (scan_wrap)
      next_idx = (scan_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx + IDX_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt  <= '0;
      scan_idx  <= '0;
      digit_sel <= ~NUM_DIGITS'(1);
    end else begin
      scan_cnt  <= scan_wrap ? '0 : scan_cnt + SCAN_W'(1);
      scan_idx  <= next_idx;
      digit_sel <= ~(NUM_DIGITS'(1) << next_idx);
    end
  end

  assign digit_bcd = digit[scan_idx];

  segment7 u_seg (
    .bcd (digit_bcd),
    .seg (hout)
  );

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: arithmetic reference model plus directed literal checks.
module tb_stopwatch_ctrl;

  localparam int ND   = 2;
  localparam int TD   = 4;
  localparam int SD   = 2;
  localparam int MAXC = 10**ND - 1;

`ifdef STOPWATCH_HOLD_ON_OVF_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, start_stop, clear;
  logic          running, overflow;
  logic [ND-1:0] digit_sel;
  logic [3:0]    digit_bcd;
  logic [6:0]    hout;

  int errors = 0;
  int checks = 0;
  bit check_en = 1'b0;

  // Model: state 0=idle 1=run 2=pause, count as a plain integer.
  int m_state, m_phase, m_count, m_ovf, m_scan, m_idx;

  stopwatch_ctrl #(.NUM_DIGITS(ND), .TICK_DIV(TD), .SCAN_DIV(SD)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_stop (start_stop),
    .clear      (clear),
    .running    (running),
    .overflow   (overflow),
    .digit_sel  (digit_sel),
    .digit_bcd  (digit_bcd),
    .hout       (hout)
  );

  always #5 clk = ~clk;

  function automatic int digit_of(int value, int idx);
    return (value / (10**idx)) % 10;
  endfunction

  function automatic logic [6:0] seg_of(int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    int  n_state, n_phase, n_count, n_ovf;
    bit  tick, all9;
    if (rst) begin
      m_state = 0; m_phase = 0; m_count = 0; m_ovf = 0; m_scan = 0; m_idx = 0;
    end else begin
      tick = (m_state == 1) && (m_phase == TD - 1);
      all9 = (m_count == MAXC);
      n_state = m_state; n_phase = m_phase; n_count = m_count; n_ovf = m_ovf;
      if (clear) begin
        n_state = 0; n_phase = 0; n_count = 0; n_ovf = 0;
      end else begin
        if (tick) begin
          if (all9) begin
            n_ovf = 1;
            if (HOLD) n_state = 2;
            else      n_count = 0;
          end else begin
            n_count = m_count + 1;
          end
        end
        if (m_state == 1)      n_phase = tick ? 0 : m_phase + 1;
        else if (m_state == 0) n_phase = 0;
        if (start_stop && !(HOLD && tick && all9) && !(HOLD && m_ovf == 1))
          n_state = (m_state == 1) ? 2 : 1;
      end
      m_state = n_state; m_phase = n_phase; m_count = n_count; m_ovf = n_ovf;
      if (m_scan == SD - 1) begin
        m_scan = 0;
        m_idx  = (m_idx + 1) % ND;
      end else begin
        m_scan = m_scan + 1;
      end
    end
  end

  always @(negedge clk) begin
    logic [ND-1:0] exp_sel;
    int            exp_bcd;
    if (check_en) begin
      exp_sel         = '1;
      exp_sel[m_idx]  = 1'b0;
      exp_bcd         = digit_of(m_count, m_idx);
      chk("cyc_running",   running,   (m_state == 1) ? 1 : 0);
      chk("cyc_overflow",  overflow,  m_ovf);
      chk("cyc_digit_sel", digit_sel, exp_sel);
      chk("cyc_digit_bcd", digit_bcd, exp_bcd);
      chk("cyc_hout",      hout,      seg_of(exp_bcd));
    end
  end

  initial begin
    rst = 1'b1; start_stop = 1'b0; clear = 1'b0;
    @(posedge clk); #1 check_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_running",   running,   0);
    chk("rst_overflow",  overflow,  0);
    chk("rst_digit_sel", digit_sel, 2'b10);
    chk("rst_digit_bcd", digit_bcd, 0);
    chk("rst_hout",      hout,      7'b1000000);
    @(posedge clk); #1 rst = 1'b0;

    // Count and carry: 40 run cycles give 10 ticks.
    start_stop = 1'b1; step(1); start_stop = 1'b0;
    step(40);
    @(negedge clk);
    chk("cnt_model_10", m_count, 10);
    chk("cnt_running",  running, 1);
    chk("cnt_digit",    digit_bcd, digit_of(10, m_idx));
    chk("cnt_hout",     hout, (m_idx == 1) ? 7'b1111001 : 7'b1000000);

    // Pause with prescaler left at 2, then resume: tick on the second run cycle.
    step(1);
    start_stop = 1'b1; step(1); start_stop = 1'b0;
    chk("pause_phase_model", m_phase, 2);
    step(20);
    @(negedge clk);
    chk("pause_running", running, 0);
    chk("pause_model",   m_count, 10);
    chk("pause_digit",   digit_bcd, digit_of(10, m_idx));
    step(1);
    start_stop = 1'b1; step(1); start_stop = 1'b0;
    step(0);
    @(posedge clk);
    @(negedge clk);
    chk("resume_no_tick_yet", digit_bcd, digit_of(10, m_idx));
    chk("resume_model_10",    m_count, 10);
    step(1);
    @(negedge clk);
    chk("resume_tick_model", m_count, 11);
    chk("resume_tick_digit", digit_bcd, 1);

    // Clear beats start_stop in the same cycle.
    step(1);
    clear = 1'b1; start_stop = 1'b1; step(1); clear = 1'b0; start_stop = 1'b0;
    @(negedge clk);
    chk("clr_running", running, 0);
    chk("clr_digit",   digit_bcd, 0);
    chk("clr_state",   m_state, 0);
    step(5);
    @(negedge clk);
    chk("clr_idle_running", running, 0);
    chk("clr_idle_digit",   digit_bcd, 0);

    // Run to 99, then the overflowing tick.
    step(1);
    start_stop = 1'b1; step(1); start_stop = 1'b0;
    step(396);
    @(negedge clk);
    chk("pre_ovf_model", m_count, 99);
    chk("pre_ovf_digit", digit_bcd, 9);
    chk("pre_ovf_flag",  overflow, 0);
    step(4);
    @(negedge clk);
    chk("ovf_flag", overflow, 1);
`ifdef STOPWATCH_HOLD_ON_OVF_EN
    chk("ovf_digit",   digit_bcd, 9);
    chk("ovf_running", running, 0);
`else
    chk("ovf_digit",   digit_bcd, 0);
    chk("ovf_running", running, 1);
`endif
    step(1);
    start_stop = 1'b1; step(1); start_stop = 1'b0;
    step(2);
    @(negedge clk);
    chk("ovf_sticky",      overflow, 1);
    chk("ovf_after_ss_run", running, 0);
    step(1);
    clear = 1'b1; step(1); clear = 1'b0;
    @(negedge clk);
    chk("ovf_cleared",     overflow, 0);
    chk("ovf_clr_running", running, 0);
    chk("ovf_clr_digit",   digit_bcd, 0);

    step(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
